// File: rtl/ffram_write_scheduler.sv
// Write-port scheduler for the cache flip-flop RAM: arbitrates refill (A) against
// store (B) writes, runs the flush sweep, and forwards in-flight write data to reads.
module ffram_write_scheduler #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 6,
    parameter int                    STARVE_LIMIT = 4,
    parameter logic [DATA_WIDTH-1:0] FLUSH_DATA   = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush_req,
    output logic                  flush_busy,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_e;

    localparam int              STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic                  grant_a, grant_b;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fcnt_d     = fcnt_q;
        starve_d   = starve_q;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        flush_busy = 1'b0;
        ram_we     = 1'b0;
        ram_waddr  = '0;
        ram_wdata  = '0;

        case (state_q)
            IDLE: begin
                grant_b = b_valid && (!a_valid || starve_q == STARVE_MAX);
                grant_a = a_valid && !grant_b;
                ram_we  = grant_a || grant_b;
                if (grant_b) begin
                    ram_waddr = b_addr;
                    ram_wdata = b_data;
                end else if (grant_a) begin
                    ram_waddr = a_addr;
                    ram_wdata = a_data;
                end
                if (grant_b || !b_valid) begin
                    starve_d = '0;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 1'b1;
                end
                // A grant taken alongside flush_req still lands; the sweep overwrites it.
                if (flush_req) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_busy = 1'b1;
                ram_we     = 1'b1;
                ram_waddr  = fcnt_q;
                ram_wdata  = FLUSH_DATA;
                fcnt_d     = fcnt_q + 1'b1;
                if (&fcnt_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Keep the RAM and both requesters quiet for as long as reset is held.
        if (!resetn) begin
            grant_a    = 1'b0;
            grant_b    = 1'b0;
            flush_busy = 1'b0;
            ram_we     = 1'b0;
            ram_waddr  = '0;
            ram_wdata  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            fcnt_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            starve_q <= starve_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign ram_raddr = rd_addr;
    assign rd_data   = (ram_we && ram_waddr == rd_addr) ? ram_wdata : ram_rdata;

endmodule

// File: tb/tb_ffram_write_scheduler.sv
// Directed bench for ffram_write_scheduler: a vector table for arbitration and
// forwarding, plus hand-written flush and mid-sweep reset sequences.
module tb_ffram_write_scheduler;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush_req;
    logic          flush_busy;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr, rd_addr, ram_waddr, ram_raddr;
    logic [DW-1:0] a_data, b_data, rd_data, ram_wdata, ram_rdata;
    logic          ram_we;

    logic [DW-1:0] mem [1<<AW];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ffram_write_scheduler #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(4),
        .FLUSH_DATA  ('0)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush_req (flush_req),
        .flush_busy(flush_busy),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    // Behavioural model of the flip-flop RAM: async read, write at posedge.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
    end
    assign ram_rdata = mem[ram_raddr];

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic [AW-1:0] ra;
        logic          e_ar;
        logic          e_br;
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t vec [15];

    function automatic vec_t mk(logic av, logic [AW-1:0] aa, logic [DW-1:0] ad,
                                logic bv, logic [AW-1:0] ba, logic [DW-1:0] bd,
                                logic [AW-1:0] ra, logic e_ar, logic e_br, logic e_we,
                                logic [AW-1:0] e_wa, logic [DW-1:0] e_wd, logic [DW-1:0] e_rd);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd; v.ra = ra;
        v.e_ar = e_ar; v.e_br = e_br; v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
        rd_addr = v.ra;
    endtask

    initial begin
        // A-side contention vector: A wins, rd_addr 13 is never written so reads its preload.
        vec_t va, vb;
        va = mk(1, 20, 32'h2020, 1, 9, 32'hBEEF, 13, 1, 0, 1, 20, 32'h2020, 32'hA000_000D);
        vb = mk(1, 20, 32'h2020, 1, 9, 32'hBEEF, 13, 0, 1, 1,  9, 32'hBEEF, 32'hA000_000D);
        vec[0]  = mk(1,  5, 32'h55,   0, 0, 0,         5, 1, 0, 1,  5, 32'h55,   32'h55);
        vec[1]  = mk(0,  0, 0,        0, 0, 0,         5, 0, 0, 0,  0, 0,        32'h55);
        vec[2]  = mk(0,  0, 0,        1, 9, 32'hBEEF,  9, 0, 1, 1,  9, 32'hBEEF, 32'hBEEF);
        vec[3]  = va;
        vec[4]  = va;
        vec[5]  = va;
        vec[6]  = va;
        vec[7]  = vb;
        vec[8]  = va;
        vec[9]  = mk(1, 20, 32'h2020, 0, 9, 32'hBEEF, 13, 1, 0, 1, 20, 32'h2020, 32'hA000_000D);
        vec[10] = va;
        vec[11] = va;
        vec[12] = va;
        vec[13] = va;
        vec[14] = vb;

        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | i;

        resetn    = 1'b0;
        flush_req = 1'b0;
        drive(vec[0]);

        // Reset holds everything quiet even with a live A request.
        repeat (2) @(negedge clk);
        #1;
        check("rst_a_ready", 32'(a_ready), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_flush_busy", 32'(flush_busy), 0);
        check("rst_ram_waddr", 32'(ram_waddr), 0);
        check("rst_ram_wdata", ram_wdata, 0);

        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            drive(vec[i]);
            #1;
            check($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vec[i].e_ar));
            check($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vec[i].e_br));
            check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vec[i].e_we));
            check($sformatf("v%0d_ram_waddr", i), 32'(ram_waddr), 32'(vec[i].e_wa));
            check($sformatf("v%0d_ram_wdata", i), ram_wdata, vec[i].e_wd);
            check($sformatf("v%0d_rd_data", i), rd_data, vec[i].e_rd);
            @(negedge clk);
        end

        // Flush request with a simultaneous A grant, then the full sweep.
        flush_req = 1'b1;
        a_valid = 1'b1; a_addr = 7; a_data = 32'h77;
        b_valid = 1'b0;
        rd_addr = 3;
        #1;
        check("flush_start_busy", 32'(flush_busy), 0);
        check("flush_start_a_ready", 32'(a_ready), 1);
        @(negedge clk);
        for (int i = 0; i < (1 << AW); i++) begin
            flush_req = (i == 30);
            rd_addr = (i == 10) ? AW'(10) : AW'(3);
            #1;
            check($sformatf("sweep%0d_busy", i), 32'(flush_busy), 1);
            check($sformatf("sweep%0d_we", i), 32'(ram_we), 1);
            check($sformatf("sweep%0d_waddr", i), 32'(ram_waddr), 32'(i));
            check($sformatf("sweep%0d_wdata", i), ram_wdata, 0);
            check($sformatf("sweep%0d_a_ready", i), 32'(a_ready), 0);
            if (i == 10) check("sweep_fwd_rd_data", rd_data, 0);
            @(negedge clk);
        end
        flush_req = 1'b0;
        #1;
        check("post_flush_busy", 32'(flush_busy), 0);
        check("post_flush_a_ready", 32'(a_ready), 1);
        check("post_flush_waddr", 32'(ram_waddr), 7);
        check("post_flush_rd3", rd_data, 0);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        check("post_flush_idle_busy", 32'(flush_busy), 0);
        check("post_flush_idle_we", 32'(ram_we), 0);

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        for (int i = 0; i < 20; i++) @(negedge clk);
        #1;
        check("mid_sweep_waddr", 32'(ram_waddr), 20);
        #1;
        resetn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(flush_busy), 0);
        check("mid_rst_we", 32'(ram_we), 0);
        @(negedge clk);
        resetn = 1'b1;
        a_valid = 1'b1; a_addr = 2; a_data = 32'h22;
        #1;
        check("after_rst_busy", 32'(flush_busy), 0);
        check("after_rst_a_ready", 32'(a_ready), 1);
        check("after_rst_waddr", 32'(ram_waddr), 2);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        check("after_rst_idle_busy", 32'(flush_busy), 0);
        check("after_rst_idle_we", 32'(ram_we), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
